// File: rtl/arb_requester.sv
// Client-side requester for a two-way req/gnt arbiter: queues jobs, requests, streams one beat per grant.
// Optional statistics counters are enabled by defining ARB_REQ_STATS_EN.
module arb_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic             beat_last,
    output logic             busy,
`ifdef ARB_REQ_STATS_EN
    output logic [15:0]      stat_jobs,
    output logic [15:0]      stat_timeouts,
    output logic [7:0]       stat_wait_max,
`endif
    output logic             timeout_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_REL,
        S_REL_RETRY
    } state_t;

    state_t            state_reg, state_next;
    logic              req_reg;
    logic              timeout_err_reg;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [LEN_W-1:0]  beats_left_reg, beats_left_next;
    logic              pop;
    logic              push;
    logic              timeout_hit;

    logic [LEN_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              fifo_full, fifo_empty;
    logic [LEN_W-1:0]  head_len, next_len;

    assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign head_len   = mem[rd_ptr_reg];
    assign next_len   = mem[rd_ptr_reg + AW'(1)];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign job_ready   = !fifo_full || pop;
    assign push        = job_valid && job_ready;
    assign busy        = (state_reg != S_IDLE) || !fifo_empty;
    assign req         = req_reg;
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= job_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        beats_left_next = beats_left_reg;
        pop             = 1'b0;
        timeout_hit     = 1'b0;
        beat_valid      = 1'b0;
        beat_last       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (head_len != '0) begin
                        state_next      = S_REQ;
                        wait_cnt_next   = '0;
                        beats_left_next = head_len;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_next = S_XFER;
                end else if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = S_REL_RETRY;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_XFER: begin
                if (gnt) begin
                    beat_valid      = 1'b1;
                    beats_left_next = beats_left_reg - LEN_W'(1);
                    if (beats_left_reg == LEN_W'(1)) begin
                        beat_last  = 1'b1;
                        state_next = S_REL;
                    end
                end else begin
                    state_next    = S_REQ;
                    wait_cnt_next = '0;
                end
            end
            S_REL: begin
                // Jump straight to the next queued job so the req-low gap stays one cycle.
                pop = 1'b1;
                if (count_reg > (AW+1)'(1) && next_len != '0) begin
                    state_next      = S_REQ;
                    wait_cnt_next   = '0;
                    beats_left_next = next_len;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_REL_RETRY: begin
                state_next    = S_REQ;
                wait_cnt_next = '0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            req_reg         <= 1'b0;
            timeout_err_reg <= 1'b0;
            wait_cnt_reg    <= '0;
            beats_left_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= (state_next == S_REQ) || (state_next == S_XFER);
            timeout_err_reg <= timeout_hit;
            wait_cnt_reg    <= wait_cnt_next;
            beats_left_reg  <= beats_left_next;
        end
    end

`ifdef ARB_REQ_STATS_EN
    localparam int WAIT_X = (WAIT_W > 8) ? WAIT_W : 8;

    logic [15:0]       stat_jobs_reg, stat_timeouts_reg;
    logic [7:0]        stat_wait_max_reg;
    logic [WAIT_X-1:0] wait_ext;
    logic [7:0]        wait_sat;

    assign wait_ext = WAIT_X'(wait_cnt_reg);
    assign wait_sat = (wait_ext > WAIT_X'(255)) ? 8'hFF : wait_ext[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_jobs_reg     <= '0;
            stat_timeouts_reg <= '0;
            stat_wait_max_reg <= '0;
        end else begin
            if (state_reg == S_REL && stat_jobs_reg != 16'hFFFF)
                stat_jobs_reg <= stat_jobs_reg + 16'd1;
            if (timeout_hit && stat_timeouts_reg != 16'hFFFF)
                stat_timeouts_reg <= stat_timeouts_reg + 16'd1;
            if (state_reg == S_REQ && gnt && wait_sat > stat_wait_max_reg)
                stat_wait_max_reg <= wait_sat;
        end
    end

    assign stat_jobs     = stat_jobs_reg;
    assign stat_timeouts = stat_timeouts_reg;
    assign stat_wait_max = stat_wait_max_reg;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: queue-based reference model checked every cycle, plus directed literal timelines.
module tb_arb_requester;

    localparam int DEPTH   = 4;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             job_valid = 1'b0;
    logic [LEN_W-1:0] job_len = '0;
    logic             gnt = 1'b0;
    logic             job_ready, req, beat_valid, beat_last, busy, timeout_err;
`ifdef ARB_REQ_STATS_EN
    logic [15:0]      stat_jobs, stat_timeouts;
    logic [7:0]       stat_wait_max;
`endif

    arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .job_valid   (job_valid),
        .job_len     (job_len),
        .job_ready   (job_ready),
        .req         (req),
        .gnt         (gnt),
        .beat_valid  (beat_valid),
        .beat_last   (beat_last),
        .busy        (busy),
`ifdef ARB_REQ_STATS_EN
        .stat_jobs     (stat_jobs),
        .stat_timeouts (stat_timeouts),
        .stat_wait_max (stat_wait_max),
`endif
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b (req,bv,bl,busy,rdy,to)", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {req, beat_valid, beat_last, busy, job_ready, timeout_err};
    endfunction

    // Reference model: job queue plus request/grant bookkeeping, evaluated mid-cycle.
    int q[$];
    bit m_on, m_granted;
    int m_left, m_wait, m_rel, cyc = 0;

    initial forever begin
        bit pop_now, e_bv, do_push;
        logic [5:0] exp_v;
        int len;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            q.delete();
            m_on = 0; m_granted = 0; m_left = 0; m_wait = 0; m_rel = 0;
        end
        pop_now = (m_rel == 1) || (!m_on && m_rel == 0 && q.size() > 0 && q[0] == 0);
        e_bv    = m_on && m_granted && gnt;
        exp_v   = {m_on, e_bv, e_bv && m_left == 1,
                   m_on || m_rel != 0 || q.size() > 0,
                   q.size() < DEPTH || pop_now, m_rel == 2};
        check($sformatf("model_cyc%0d", cyc), int'(outs()), int'(exp_v));
        if (rst_n) begin
            do_push = job_valid && exp_v[1];
            len     = int'(job_len);
            if (m_rel == 1) begin
                void'(q.pop_front());
                m_rel = 0;
                if (q.size() > 0 && q[0] != 0) begin
                    m_on = 1; m_granted = 0; m_wait = 0; m_left = q[0];
                end
            end else if (m_rel == 2) begin
                m_rel = 0; m_on = 1; m_granted = 0; m_wait = 0;
            end else if (!m_on) begin
                if (q.size() > 0) begin
                    if (q[0] == 0) void'(q.pop_front());
                    else begin
                        m_on = 1; m_granted = 0; m_wait = 0; m_left = q[0];
                    end
                end
            end else if (!m_granted) begin
                if (gnt) m_granted = 1;
                else if (m_wait == TIMEOUT - 1) begin
                    m_on = 0; m_rel = 2;
                end else m_wait++;
            end else begin
                if (gnt) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_on = 0; m_rel = 1;
                    end
                end else begin
                    m_granted = 0; m_wait = 0;
                end
            end
            if (do_push) q.push_back(len);
        end
        cyc++;
    end

    task automatic step(input bit jv, input int len, input bit g);
        @(negedge clk);
        job_valid = jv;
        job_len   = LEN_W'(len);
        gnt       = g;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] t2 [8];
        logic [5:0] t3 [10];
        logic [5:0] t5 [13];
        int nb;
        t2 = '{6'b000010, 6'b000110, 6'b100110, 6'b110110,
               6'b110110, 6'b111110, 6'b000110, 6'b000010};
        t3 = '{6'b000010, 6'b000110, 6'b100110, 6'b110110, 6'b111110,
               6'b000110, 6'b100110, 6'b111110, 6'b000110, 6'b000010};
        t5 = '{6'b000010, 6'b000110, 6'b100110, 6'b110110, 6'b110110,
               6'b100110, 6'b100110, 6'b100110, 6'b100110, 6'b110110,
               6'b111110, 6'b000110, 6'b000010};

        step(0, 0, 0);
        check("reset_state", int'(outs()), 6'b000010);
        step(0, 0, 1);
        #1 rst_n = 1'b1;
        step(0, 0, 1);
        check("gnt_ignored_idle", int'(outs()), 6'b000010);

        for (int i = 0; i < 8; i++) begin
            step(i == 0, 3, 1);
            check($sformatf("len3_c%0d", i), int'(outs()), int'(t2[i]));
        end

        for (int i = 0; i < 10; i++) begin
            step(i < 2, (i == 0) ? 2 : 1, 1);
            check($sformatf("b2b_c%0d", i), int'(outs()), int'(t3[i]));
        end

        for (int i = 0; i < 23; i++) begin
            step(i == 0, 1, i >= 19);
            if (i == 17) check("tmo_last_req", int'(outs()), 6'b100110);
            if (i == 18) check("tmo_pulse", int'(outs()), 6'b000111);
            if (i == 19) check("tmo_rereq", int'(outs()), 6'b100110);
            if (i == 20) check("tmo_job_kept", int'(outs()), 6'b111110);
            if (i == 22) check("tmo_done", int'(outs()), 6'b000010);
        end

        for (int i = 0; i < 13; i++) begin
            step(i == 0, 4, !(i >= 5 && i <= 7));
            check($sformatf("preempt_c%0d", i), int'(outs()), int'(t5[i]));
        end

        nb = 0;
        for (int i = 0; i < 20; i++) begin
            step(i < 5, 1, i >= 5);
            if (beat_valid) nb++;
            if (i == 4) check("full_not_ready", int'(outs()), 6'b100100);
            if (i == 5) check("full_still", int'(outs()), 6'b100100);
            if (i == 19) check("full_drained", int'(outs()), 6'b000010);
        end
        checks++;
        if (nb != 4) begin
            errors++;
            $display("FAIL full_beat_count: got %0d beats want 4", nb);
        end

        for (int i = 0; i < 3; i++) begin
            step(i == 0, 0, 1);
            check($sformatf("zero_len_c%0d", i), int'(outs()), (i == 1) ? 6'b000110 : 6'b000010);
        end

        for (int i = 0; i < 5; i++) step(i == 0, 5, 1);
        check("pre_reset_beat", int'(outs()), 6'b110110);
        #1 rst_n = 1'b0;
        #1 check("reset_async", int'(outs()), 6'b000010);
        step(0, 0, 1);
        step(0, 0, 1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1);
            check($sformatf("post_reset_c%0d", i), int'(outs()), 6'b000010);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
